da2pmod_axil_slave: RTL and testbench
=====================================

DA2PMOD_AXIL_SLAVE -- requirements
Module: da2pmod_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have ports ACLK in 1 clock; ARESET in 1 reset, asynchronous, active-high.
REQ-004 SHALL have AW channel: S_AXI_AWADDR in 5, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-005 SHALL have W channel: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-006 SHALL have B channel: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-007 SHALL have AR/R channels: S_AXI_ARADDR in 5, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-008 SHALL have Pmod outputs: DA2_SYNC out 1 (frame, active-low), DA2_SCLK out 1, DA2_DINA out 1, DA2_DINB out 1.

Function
REQ-009 Register map SHALL be: 0x00 CTRL, 0x04 DATA_A, 0x08 DATA_B, 0x0C CLKDIV (all full 32-bit R/W, byte-strobed, read back exactly as written), 0x10 STATUS (RO, bit0 busy, bit1 pending, others 0).
REQ-010 Write SHALL be accepted only when AWVALID and WVALID both high and BVALID low; AWREADY and WREADY pulse high together for exactly one cycle; register updates that same edge.
REQ-011 BVALID SHALL assert the cycle after acceptance and hold until BREADY; BRESP OKAY for 0x00–0x10 (STATUS writes ignored), SLVERR for 0x14–0x1C.
REQ-012 ARREADY SHALL pulse one cycle when ARVALID high and RVALID low; RVALID asserts next cycle with RDATA, holds stable until RREADY; RRESP OKAY mapped, SLVERR unmapped with RDATA 0.
REQ-013 Read and write channels SHALL operate independently and concurrently.
REQ-014 A write to DATA_B with CTRL[0]=1 SHALL trigger a DAC frame; CTRL[1] written 1 SHALL also trigger (CTRL[1] stored but trigger is edge of the write).
REQ-015 Trigger while busy SHALL set pending (one deep, further triggers merge); pending frame starts after current GAP.
REQ-016 Frame engine states SHALL be IDLE, LOAD, SHIFT, GAP; IDLE->LOAD on trigger/pending, LOAD latches {4'b0000, DATA_A[11:0]} and {4'b0000, DATA_B[11:0]} into shift registers and CLKDIV[7:0] into divider, SHIFT for 16 bits, GAP for one SCLK period with SYNC high, then IDLE.
REQ-017 SCLK half-period SHALL be CLKDIV[7:0]+1 ACLK cycles; SCLK idles high; DIN changes on SCLK rising edge, MSB first, SYNC low from first bit until after 16th falling edge.
REQ-018 Register writes during a frame SHALL not affect the frame in flight.
REQ-019 STATUS.busy SHALL be high from LOAD through GAP inclusive.

Reset
REQ-020 ARESET SHALL asynchronously clear all registers to 0, all READY/VALID outputs low, BRESP/RRESP/RDATA 0, engine to IDLE, pending 0, DA2_SYNC=1, DA2_SCLK=1, DIN 0; reset mid-frame aborts the frame.

Configuration
REQ-021 With DA2PMOD_IRQ_EN defined, output IRQ (1 bit) SHALL pulse high one ACLK cycle at GAP->IDLE when CTRL[2]=1; without it, no IRQ port and CTRL[2] is storage only.

Structure
REQ-022 Package da2pmod_pkg SHALL hold register offset constants, RESP_OKAY/RESP_SLVERR, and the frame-state enum.
REQ-023 Frame engine SHALL be sub-module da2pmod_spi_tx; AXI decode and register file in top.

Verification
REQ-024 Write 0x1,0x2,0x3,0x4 to 0x00–0x0C, read back -> 0x1,0x2,0x3,0x4, all OKAY.
REQ-025 CTRL=1, CLKDIV=0, DATA_A=0xABC, write DATA_B=0x123 -> SYNC low 16 SCLK periods of 2 ACLK, DINA bits 0x0ABC, DINB 0x0123, STATUS.busy 1 then 0.
REQ-026 Second DATA_B write during frame, DATA_A changed to 0x555 -> first frame unchanged, pending=1, second frame carries 0x0555.
REQ-027 Read 0x14 -> RRESP SLVERR, RDATA 0; write 0x18 -> BRESP SLVERR, no register changes.
REQ-028 Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and RDATA stable, no new acceptance; assert ARESET mid-frame -> SYNC=1, SCLK=1, busy=0 immediately.

Source files
------------

// File: rtl/da2pmod_pkg.sv
// ---------------------------------------------------------------------------
// da2pmod_pkg: register offsets, AXI response codes, frame-state enum. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package da2pmod_pkg;

  localparam logic [4:0] REG_CTRL   = 5'h00;
  localparam logic [4:0] REG_DATA_A = 5'h04;
  localparam logic [4:0] REG_DATA_B = 5'h08;
  localparam logic [4:0] REG_CLKDIV = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } frame_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/da2pmod_spi_tx.sv
// ---------------------------------------------------------------------------
// da2pmod_spi_tx: dual-channel 16-bit frame serialiser for the Pmod DA2. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da2pmod_spi_tx
  import da2pmod_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trigger_i,
  input  logic [11:0] data_a_i,
  input  logic [11:0] data_b_i,
  input  logic [7:0]  clkdiv_i,
  output logic        busy_o,
  output logic        pending_o,
  output logic        done_o,
  output logic        sync_o,
  output logic        sclk_o,
  output logic        dina_o,
  output logic        dinb_o
);

  frame_state_e state_q;
  logic         pending_q;
  logic         done_q;
  logic [7:0]   div_q;
  logic [8:0]   cnt_q;
  logic [3:0]   bit_q;
  logic [15:0]  sh_a_q;
  logic [15:0]  sh_b_q;
  logic         sync_q;
  logic         sclk_q;
  logic         dina_q;
  logic         dinb_q;

  logic [15:0]  frame_a_d;
  logic [15:0]  frame_b_d;

  assign frame_a_d = {4'b0000, data_a_i};
  assign frame_b_d = {4'b0000, data_b_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      sync_q    <= 1'b1;
      sclk_q    <= 1'b1;
      dina_q    <= 1'b0;
      dinb_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Only one frame can be queued; later triggers fold into it.
      if (trigger_i && (state_q != ST_IDLE)) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (trigger_i || pending_q) begin
            state_q   <= ST_LOAD;
            pending_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          div_q   <= clkdiv_i;
          cnt_q   <= '0;
          bit_q   <= '0;
          sync_q  <= 1'b0;
          sclk_q  <= 1'b1;
          dina_q  <= frame_a_d[15];
          dinb_q  <= frame_b_d[15];
          sh_a_q  <= {frame_a_d[14:0], 1'b0};
          sh_b_q  <= {frame_b_d[14:0], 1'b0};
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt_q[7:0] == div_q) begin
            cnt_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_q == 4'd15) begin
              sclk_q  <= 1'b1;
              sync_q  <= 1'b1;
              dina_q  <= 1'b0;
              dinb_q  <= 1'b0;
              state_q <= ST_GAP;
            end else begin
              // Data moves on the rising edge so it is stable for the DAC's falling-edge sample.
              sclk_q <= 1'b1;
              dina_q <= sh_a_q[15];
              dinb_q <= sh_b_q[15];
              sh_a_q <= {sh_a_q[14:0], 1'b0};
              sh_b_q <= {sh_b_q[14:0], 1'b0};
              bit_q  <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == {div_q, 1'b1}) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign pending_o = pending_q;
  assign done_o    = done_q;
  assign sync_o    = sync_q;
  assign sclk_o    = sclk_q;
  assign dina_o    = dina_q;
  assign dinb_o    = dinb_q;

endmodule

`default_nettype wire

// File: rtl/da2pmod_axil_slave.sv
// ---------------------------------------------------------------------------
// da2pmod_axil_slave: AXI4-Lite register file driving a Pmod DA2 frame engine;
// define DA2PMOD_IRQ_EN to add the end-of-frame IRQ output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da2pmod_axil_slave
  import da2pmod_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
`ifdef DA2PMOD_IRQ_EN
  output logic                            IRQ,
`endif
  output logic                            DA2_SYNC,
  output logic                            DA2_SCLK,
  output logic                            DA2_DINA,
  output logic                            DA2_DINB
);

  logic        awready_q, awready_d;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        arready_q, arready_d;
  logic        rvalid_q;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ctrl_q, data_a_q, data_b_q, clkdiv_q;

  logic        wr_en, rd_en, wr_mapped, trigger_w;
  logic        busy_w, pending_w, done_w;
  logic [4:0]  waddr_w, raddr_w;

  assign waddr_w = {S_AXI_AWADDR[4:2], 2'b00};
  assign raddr_w = {S_AXI_ARADDR[4:2], 2'b00};

  // Ready is a one-cycle registered pulse, so a handshake can only land on the cycle after it rises.
  assign awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
  assign wr_en     = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
  assign rd_en     = arready_q & S_AXI_ARVALID;
  assign wr_mapped = (waddr_w <= REG_STATUS);

  assign trigger_w = wr_en & (((waddr_w == REG_DATA_B) & ctrl_q[0]) |
                              ((waddr_w == REG_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[1]));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      ctrl_q    <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      clkdiv_q  <= '0;
    end else begin
      awready_q <= awready_d;
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        case (waddr_w)
          REG_CTRL:   ctrl_q   <= apply_strb(ctrl_q,   S_AXI_WDATA, S_AXI_WSTRB);
          REG_DATA_A: data_a_q <= apply_strb(data_a_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_DATA_B: data_b_q <= apply_strb(data_b_q, S_AXI_WDATA, S_AXI_WSTRB);
          REG_CLKDIV: clkdiv_q <= apply_strb(clkdiv_q, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (raddr_w)
      REG_CTRL:   rdata_d = ctrl_q;
      REG_DATA_A: rdata_d = data_a_q;
      REG_DATA_B: rdata_d = data_b_q;
      REG_CLKDIV: rdata_d = clkdiv_q;
      REG_STATUS: rdata_d = {30'd0, pending_w, busy_w};
      default:    rresp_d = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= arready_d;
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end
    end
  end

  da2pmod_spi_tx u_spi_tx (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .trigger_i (trigger_w),
    .data_a_i  (data_a_q[11:0]),
    .data_b_i  (data_b_q[11:0]),
    .clkdiv_i  (clkdiv_q[7:0]),
    .busy_o    (busy_w),
    .pending_o (pending_w),
    .done_o    (done_w),
    .sync_o    (DA2_SYNC),
    .sclk_o    (DA2_SCLK),
    .dina_o    (DA2_DINA),
    .dinb_o    (DA2_DINB)
  );

`ifdef DA2PMOD_IRQ_EN
  assign IRQ = done_w & ctrl_q[2];
`else
  logic unused_done;
  assign unused_done = done_w;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_da2pmod_axil_slave.sv
// ---------------------------------------------------------------------------
// tb_da2pmod_axil_slave: directed self-checking bench for da2pmod_axil_slave. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_da2pmod_axil_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
`ifdef DA2PMOD_IRQ_EN
  logic        IRQ;
`endif
  logic        DA2_SYNC, DA2_SCLK, DA2_DINA, DA2_DINB;

  int passed = 0;
  int total  = 0;

  always #5 ACLK = ~ACLK;

  da2pmod_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
`ifdef DA2PMOD_IRQ_EN
    .IRQ(IRQ),
`endif
    .DA2_SYNC(DA2_SYNC), .DA2_SCLK(DA2_SCLK), .DA2_DINA(DA2_DINA), .DA2_DINB(DA2_DINB)
  );

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic ok);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin @(negedge ACLK); n++; end
    ok = (n < 20);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    ok = ok && S_AXI_BVALID;
    resp = S_AXI_BRESP;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic ok);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    ok = (n < 20);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    ok = ok && S_AXI_RVALID;
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    logic [31:0] d; logic [1:0] r; logic rok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      axi_read(5'h10, d, r, rok);
      if (rok && d == 32'd0) ok = 1'b1;
    end
  endtask

  // Shifts DINA/DINB in on every SCLK falling edge while SYNC is low.
  task automatic capture_frame(output logic [15:0] a, output logic [15:0] b,
                               output int low_cycles, output int falls, output logic ok);
    int n; logic prev;
    a = '0; b = '0; low_cycles = 0; falls = 0; prev = 1'b1; n = 0;
    while (DA2_SYNC !== 1'b0 && n < 400) begin @(negedge ACLK); n++; end
    ok = (DA2_SYNC === 1'b0);
    while (DA2_SYNC === 1'b0 && low_cycles < 400) begin
      if (prev && !DA2_SCLK) begin
        a = {a[14:0], DA2_DINA}; b = {b[14:0], DA2_DINB}; falls++;
      end
      prev = DA2_SCLK; low_cycles++;
      @(negedge ACLK);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic ok;
    repeat (2) @(negedge ACLK);
    total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0)
      $display("FAIL reset_handshake: got %b expected 00000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}); else passed++;
    total++; if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'd0)
      $display("FAIL reset_resp_data: got %h expected 0", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}); else passed++;
    total++; if ({DA2_SYNC, DA2_SCLK, DA2_DINA, DA2_DINB} !== 4'b1100)
      $display("FAIL reset_pmod: got %b expected 1100", {DA2_SYNC, DA2_SCLK, DA2_DINA, DA2_DINB}); else passed++;
    ARESET = 1'b0;
    axi_read(5'h00, d, r, ok);
    total++; if (!ok || d !== 32'd0 || r !== OKAY)
      $display("FAIL reset_ctrl: got %h/%b expected 0/00", d, r); else passed++;
    axi_read(5'h10, d, r, ok);
    total++; if (!ok || d !== 32'd0)
      $display("FAIL reset_status: got %h expected 0", d); else passed++;
  endtask

  task automatic test_regs();
    logic [31:0] d; logic [1:0] r; logic ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, r, ok);
      total++; if (!ok || r !== OKAY) $display("FAIL reg_write_%0d: resp %b ok %b expected 00", i, r, ok); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, r, ok);
      total++; if (!ok || d !== 32'(i + 1) || r !== OKAY)
        $display("FAIL reg_read_%0d: got %h/%b expected %h/00", i, d, r, 32'(i + 1)); else passed++;
    end
    wait_idle(ok);
    total++; if (!ok) $display("FAIL regs_idle: busy never cleared"); else passed++;
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'b0101, r, ok);
    axi_read(5'h0C, d, r, ok);
    total++; if (!ok || d !== 32'h00FF_00FF) $display("FAIL byte_strobe: got %h expected 00ff00ff", d); else passed++;
    axi_write(5'h0C, 32'h0, 4'hF, r, ok);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, r, ok);
    total++; if (!ok || r !== OKAY) $display("FAIL status_write_resp: got %b expected 00", r); else passed++;
    axi_read(5'h10, d, r, ok);
    total++; if (!ok || d !== 32'd0) $display("FAIL status_ro: got %h expected 0", d); else passed++;
  endtask

  task automatic test_slverr();
    logic [31:0] d; logic [1:0] r; logic ok;
    axi_read(5'h14, d, r, ok);
    total++; if (!ok || r !== SLVERR || d !== 32'd0)
      $display("FAIL read_unmapped: got %h/%b expected 0/10", d, r); else passed++;
    axi_read(5'h1C, d, r, ok);
    total++; if (!ok || r !== SLVERR) $display("FAIL read_1c: got %b expected 10", r); else passed++;
    axi_write(5'h18, 32'hDEAD_BEEF, 4'hF, r, ok);
    total++; if (!ok || r !== SLVERR) $display("FAIL write_unmapped: got %b expected 10", r); else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = (i == 3) ? 32'd0 : 32'(i + 1);
      axi_read(5'(i * 4), d, r, ok);
      total++; if (!ok || d !== e) $display("FAIL slverr_nochange_%0d: got %h expected %h", i, d, e); else passed++;
    end
  endtask

  task automatic test_frame();
    logic [31:0] d; logic [1:0] r; logic ok, cok;
    logic [15:0] a, b; int low, falls;
    axi_write(5'h00, 32'h1, 4'hF, r, ok);
    axi_write(5'h0C, 32'h0, 4'hF, r, ok);
    axi_write(5'h04, 32'hABC, 4'hF, r, ok);
    fork
      capture_frame(a, b, low, falls, cok);
      begin
        axi_write(5'h08, 32'h123, 4'hF, r, ok);
        axi_read(5'h10, d, r, ok);
        total++; if (!ok || d[0] !== 1'b1) $display("FAIL frame_busy: got %h expected busy 1", d); else passed++;
      end
    join
    total++; if (!cok || a !== 16'h0ABC) $display("FAIL frame_dina: got %h expected 0abc", a); else passed++;
    total++; if (b !== 16'h0123) $display("FAIL frame_dinb: got %h expected 0123", b); else passed++;
    total++; if (low != 32 || falls != 16) $display("FAIL frame_timing: sync low %0d falls %0d expected 32/16", low, falls); else passed++;
    repeat (4) @(negedge ACLK);
    axi_read(5'h10, d, r, ok);
    total++; if (!ok || d !== 32'd0) $display("FAIL frame_done_status: got %h expected 0", d); else passed++;
  endtask

  task automatic test_pending();
    logic [31:0] d; logic [1:0] r; logic ok;
    logic [15:0] a1, b1, a2, b2; int l1, f1, l2, f2; logic c1, c2;
    fork
      begin
        capture_frame(a1, b1, l1, f1, c1);
        capture_frame(a2, b2, l2, f2, c2);
      end
      begin
        axi_write(5'h08, 32'h123, 4'hF, r, ok);
        axi_write(5'h04, 32'h555, 4'hF, r, ok);
        axi_write(5'h08, 32'h2AA, 4'hF, r, ok);
        axi_read(5'h10, d, r, ok);
        total++; if (!ok || d !== 32'h3) $display("FAIL pending_status: got %h expected 3", d); else passed++;
      end
    join
    total++; if (!c1 || a1 !== 16'h0ABC || b1 !== 16'h0123)
      $display("FAIL pending_first_frame: got %h/%h expected 0abc/0123", a1, b1); else passed++;
    total++; if (!c2 || a2 !== 16'h0555 || b2 !== 16'h02AA)
      $display("FAIL pending_second_frame: got %h/%h expected 0555/02aa", a2, b2); else passed++;
    wait_idle(ok);
    total++; if (!ok) $display("FAIL pending_idle: busy never cleared"); else passed++;
  endtask

  task automatic test_clkdiv();
    logic [1:0] r; logic ok, cok;
    logic [15:0] a, b; int low, falls;
    axi_write(5'h0C, 32'h2, 4'hF, r, ok);
    axi_write(5'h04, 32'hFFF, 4'hF, r, ok);
    fork
      capture_frame(a, b, low, falls, cok);
      axi_write(5'h08, 32'h000, 4'hF, r, ok);
    join
    total++; if (!cok || a !== 16'h0FFF || b !== 16'h0000)
      $display("FAIL clkdiv_data: got %h/%h expected 0fff/0000", a, b); else passed++;
    total++; if (low != 96 || falls != 16)
      $display("FAIL clkdiv_timing: sync low %0d falls %0d expected 96/16", low, falls); else passed++;
    wait_idle(ok);
  endtask

  task automatic test_hold();
    logic [31:0] d; logic [1:0] r; logic ok;
    int n, acc, bad;
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h111; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
    total++; if (n >= 20) $display("FAIL hold_aw_accept: AWREADY 0 expected 1"); else passed++;
    @(negedge ACLK);
    S_AXI_WDATA = 32'h222;
    acc = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (S_AXI_AWREADY || S_AXI_WREADY) acc++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== OKAY) bad++;
      @(negedge ACLK);
    end
    total++; if (acc != 0) $display("FAIL hold_no_new_write: ready cycles %0d expected 0", acc); else passed++;
    total++; if (bad != 0) $display("FAIL hold_bvalid: unstable cycles %0d expected 0", bad); else passed++;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    S_AXI_ARADDR = 5'h08;
    acc = 0; bad = 0;
    fork
      for (int i = 0; i < 10; i++) begin
        if (S_AXI_ARREADY) acc++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h111 || S_AXI_RRESP !== OKAY) bad++;
        @(negedge ACLK);
      end
      axi_write(5'h04, 32'h333, 4'hF, r, ok);
    join
    total++; if (n >= 20 || acc != 0) $display("FAIL hold_no_new_read: ready cycles %0d expected 0", acc); else passed++;
    total++; if (bad != 0) $display("FAIL hold_rdata: unstable cycles %0d expected 0", bad); else passed++;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    axi_read(5'h04, d, r, ok);
    total++; if (!ok || d !== 32'h333) $display("FAIL concurrent_write: got %h expected 333", d); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic [1:0] r; logic ok;
    int n, hi;
    axi_write(5'h0C, 32'h3, 4'hF, r, ok);
    axi_write(5'h08, 32'h0F0, 4'hF, r, ok);
    n = 0;
    while (DA2_SYNC !== 1'b0 && n < 50) begin @(negedge ACLK); n++; end
    total++; if (n >= 50) $display("FAIL midframe_start: SYNC 1 expected 0"); else passed++;
    repeat (5) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    total++; if ({DA2_SYNC, DA2_SCLK, DA2_DINA, DA2_DINB} !== 4'b1100)
      $display("FAIL midframe_reset_pmod: got %b expected 1100", {DA2_SYNC, DA2_SCLK, DA2_DINA, DA2_DINB}); else passed++;
    @(negedge ACLK);
    ARESET = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (DA2_SYNC === 1'b1) hi++;
      @(negedge ACLK);
    end
    total++; if (hi != 20) $display("FAIL midframe_aborted: sync high %0d expected 20", hi); else passed++;
    axi_read(5'h10, d, r, ok);
    total++; if (!ok || d !== 32'd0) $display("FAIL midframe_status: got %h expected 0", d); else passed++;
    axi_read(5'h0C, d, r, ok);
    total++; if (!ok || d !== 32'd0) $display("FAIL midframe_clkdiv: got %h expected 0", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_slverr();
    test_frame();
    test_pending();
    test_clkdiv();
    test_hold();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $finish;
  end

endmodule

`default_nettype wire
